// File: rtl/iexu_conf_encoder_if.sv
// ----------------------------------------------------------------------------
// iexu_conf_encoder_if
//
// Purpose:
//   Bundles the instruction-side and decode-side handshakes of the
//   iexu_conf_encoder stage into one interface. The master modport belongs to
//   the surrounding pipeline (it supplies instructions, flush and the
//   downstream ready). The slave modport belongs to the encoder.
//
// Optional feature:
//   IEXU_ILLEGAL_CNT_EN - adds the 16-bit illegal_cnt signal.
//
// Signals:
//   flush        pipeline -> encoder  synchronous flush of buffered entries
//   in_valid     pipeline -> encoder  instruction valid
//   in_ready     encoder  -> pipeline stage can accept (registered)
//   in_instr     pipeline -> encoder  RV32I instruction word
//   out_valid    encoder  -> pipeline decoded entry valid
//   out_ready    pipeline -> encoder  downstream accepts
//   out_conf     encoder  -> pipeline iexu_conf operation code (iexu_conf_t encoding)
//   out_rs1/rs2  encoder  -> pipeline source register indices
//   out_rd       encoder  -> pipeline destination register index
//   out_imm      encoder  -> pipeline immediate operand
//   out_use_imm  encoder  -> pipeline second operand is out_imm
//   out_illegal  encoder  -> pipeline not supported by the integer unit
//   illegal_cnt  encoder  -> pipeline saturating illegal transfer count (optional)
// ----------------------------------------------------------------------------
interface iexu_conf_encoder_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    // Carried as a plain vector so this file does not depend on the package
    // being compiled first; the values are iexu_conf_pkg::iexu_conf_t codes.
    logic [3:0]      out_conf;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic            out_use_imm;
    logic            out_illegal;
`ifdef IEXU_ILLEGAL_CNT_EN
    logic [15:0]     illegal_cnt;
`endif

    modport master (
        output flush, in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_conf, out_rs1, out_rs2, out_rd,
               out_imm, out_use_imm, out_illegal
`ifdef IEXU_ILLEGAL_CNT_EN
        , input illegal_cnt
`endif
    );

    modport slave (
        input  flush, in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_conf, out_rs1, out_rs2, out_rd,
               out_imm, out_use_imm, out_illegal
`ifdef IEXU_ILLEGAL_CNT_EN
        , output illegal_cnt
`endif
    );
endinterface

// File: rtl/iexu_conf_encoder.sv
// ----------------------------------------------------------------------------
// iexu_conf_pkg / iexu_conf_encoder
//
// Purpose:
//   Decode/issue stage for the integer execution unit. RV32I OP and OP-IMM
//   words are turned into an iexu_conf operation code plus operand fields;
//   every other word is passed along flagged illegal. A 2-entry skid buffer
//   (main + skid register) gives full throughput, one cycle of latency and a
//   registered in_ready with no combinational path from out_ready.
//
// Optional feature:
//   IEXU_ILLEGAL_CNT_EN - when defined, illegal_cnt counts output transfers
//   that carry out_illegal=1, saturating at 0xFFFF. Flush does not touch it.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    iexu_conf_encoder_if.slave (handshakes, decoded fields, flush)
// ----------------------------------------------------------------------------
package iexu_conf_pkg;

    typedef enum logic [3:0] {
        add_conf = 4'd0,
        sub_conf = 4'd1,
        and_conf = 4'd2,
        or_conf  = 4'd3,
        xor_conf = 4'd4,
        sll_conf = 4'd5,
        srl_conf = 4'd6,
        sra_conf = 4'd7
    } iexu_conf_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

endpackage

module iexu_conf_encoder
    import iexu_conf_pkg::*;
#(
    parameter int XLEN = 32  // only 32 is supported
) (
    input  logic                 clk,
    input  logic                 rst_n,
    iexu_conf_encoder_if.slave   bus
);

    typedef struct packed {
        iexu_conf_t      conf;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic            illegal;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{
        conf:    add_conf,
        rs1:     5'd0,
        rs2:     5'd0,
        rd:      5'd0,
        imm:     '0,
        use_imm: 1'b0,
        illegal: 1'b0
    };

    // ------------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------------
    function automatic entry_t decode(input logic [31:0] instr);
        entry_t     e;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;

        opcode = instr[6:0];
        funct3 = instr[14:12];
        funct7 = instr[31:25];

        e.conf    = add_conf;
        e.rs1     = instr[19:15];
        e.rs2     = instr[24:20];
        e.rd      = instr[11:7];
        e.imm     = '0;
        e.use_imm = 1'b0;
        e.illegal = 1'b0;

        case (opcode)
            OPC_OP: begin
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_ZERO)     e.conf = add_conf;
                        else if (funct7 == F7_ALT) e.conf = sub_conf;
                        else                       e.illegal = 1'b1;
                    end
                    3'b111: begin
                        e.conf    = and_conf;
                        e.illegal = (funct7 != F7_ZERO);
                    end
                    3'b110: begin
                        e.conf    = or_conf;
                        e.illegal = (funct7 != F7_ZERO);
                    end
                    3'b100: begin
                        e.conf    = xor_conf;
                        e.illegal = (funct7 != F7_ZERO);
                    end
                    3'b001: begin
                        e.conf    = sll_conf;
                        e.illegal = (funct7 != F7_ZERO);
                    end
                    3'b101: begin
                        if (funct7 == F7_ZERO)     e.conf = srl_conf;
                        else if (funct7 == F7_ALT) e.conf = sra_conf;
                        else                       e.illegal = 1'b1;
                    end
                    default: e.illegal = 1'b1;  // slt / sltu
                endcase
            end

            OPC_OP_IMM: begin
                e.use_imm = 1'b1;
                e.rs2     = 5'd0;
                // Arithmetic/logic forms take the sign-extended I-immediate.
                e.imm     = {{(XLEN-12){instr[31]}}, instr[31:20]};
                case (funct3)
                    3'b000: e.conf = add_conf;
                    3'b111: e.conf = and_conf;
                    3'b110: e.conf = or_conf;
                    3'b100: e.conf = xor_conf;
                    3'b001: begin
                        e.conf    = sll_conf;
                        e.imm     = {{(XLEN-5){1'b0}}, instr[24:20]};
                        e.illegal = (funct7 != F7_ZERO);
                    end
                    3'b101: begin
                        e.imm = {{(XLEN-5){1'b0}}, instr[24:20]};
                        if (funct7 == F7_ZERO)     e.conf = srl_conf;
                        else if (funct7 == F7_ALT) e.conf = sra_conf;
                        else                       e.illegal = 1'b1;
                    end
                    default: e.illegal = 1'b1;  // slti / sltiu
                endcase
            end

            default: e.illegal = 1'b1;
        endcase

        // Illegal words travel with neutral operation fields but keep the raw
        // register-source bit fields so a trap handler can still inspect them.
        if (e.illegal) begin
            e.conf    = add_conf;
            e.rs1     = instr[19:15];
            e.rs2     = instr[24:20];
            e.rd      = 5'd0;
            e.imm     = '0;
            e.use_imm = 1'b0;
        end

        return e;
    endfunction

    // ------------------------------------------------------------------------
    // Skid buffer state
    // ------------------------------------------------------------------------
    entry_t main_d,       main_q;
    logic   main_valid_d, main_valid_q;
    entry_t skid_d,       skid_q;
    logic   skid_valid_d, skid_valid_q;
    logic   in_ready_d,   in_ready_q;

    logic   accept;
    logic   transfer;
    entry_t in_entry;

    assign accept   = bus.in_valid & in_ready_q;
    assign transfer = main_valid_q & bus.out_ready;
    assign in_entry = decode(bus.in_instr);

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path through the branches below can leave it unassigned (a latch).
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        if (bus.flush) begin
            // Flush wins over everything, including an accept this cycle.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (transfer || !main_valid_q) begin
            // Main register is free to load this cycle.
            if (skid_valid_q) begin
                // Oldest entry first; in_ready was low, so no accept can race.
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = in_entry;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            // Main is stalled; park the new entry in the skid register.
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end

        // Ready is a function of next state only, keeping out_ready off any
        // combinational path to in_ready.
        in_ready_d = !skid_valid_d;
    end

    // NOTE: the payload registers are reset along with the valid bits because
    // their reset values are architecturally visible on the output fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= RESET_ENTRY;
            main_valid_q <= 1'b0;
            skid_q       <= RESET_ENTRY;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // ------------------------------------------------------------------------
    // Optional illegal-transfer counter
    // ------------------------------------------------------------------------
`ifdef IEXU_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt_d, illegal_cnt_q;

    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        // A transfer in a flush cycle really happened downstream, so it counts;
        // entries dropped by the flush never transfer and never count.
        if (transfer && main_q.illegal && (illegal_cnt_q != 16'hFFFF)) begin
            illegal_cnt_d = illegal_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt_q <= 16'd0;
        end else begin
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign bus.illegal_cnt = illegal_cnt_q;
`endif

    // ------------------------------------------------------------------------
    // Outputs: straight from the main register
    // ------------------------------------------------------------------------
    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = main_valid_q;
    assign bus.out_conf    = main_q.conf;
    assign bus.out_rs1     = main_q.rs1;
    assign bus.out_rs2     = main_q.rs2;
    assign bus.out_rd      = main_q.rd;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_use_imm = main_q.use_imm;
    assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_iexu_conf_encoder.sv
// ----------------------------------------------------------------------------
// tb_iexu_conf_encoder
//
// Directed-vector bench for iexu_conf_encoder. Inputs are driven 1 time unit
// after each rising edge and outputs are compared at that same point, well
// away from the next active edge. Expected values are hand-decoded constants.
// Define IEXU_ILLEGAL_CNT_EN to include the illegal_cnt checks.
// ----------------------------------------------------------------------------
module tb_iexu_conf_encoder;
    import iexu_conf_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    iexu_conf_encoder_if bus ();

    iexu_conf_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] I_ADD   = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] I_SUB   = 32'h407302B3; // sub  x5,x6,x7
    localparam logic [31:0] I_ADDI  = 32'hFFF00093; // addi x1,x0,-1
    localparam logic [31:0] I_SRAI  = 32'h40415113; // srai x2,x2,4
    localparam logic [31:0] I_XOR   = 32'h0062C233; // xor  x4,x5,x6
    localparam logic [31:0] I_ANDI  = 32'h7FF47393; // andi x7,x8,0x7FF
    localparam logic [31:0] I_SLLI  = 32'h01F49493; // slli x9,x9,31
    localparam logic [31:0] I_SLT   = 32'h0020A1B3; // slt  x3,x1,x2
    localparam logic [31:0] I_LUI   = 32'h000011B7; // lui  x3,1
    localparam logic [31:0] I_BADSR = 32'h02005093; // srli with funct7=0000001

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input string tag, input iexu_conf_t conf,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] imm,
                                input logic use_imm, input logic illegal);
        check({tag, ".valid"},   32'(bus.out_valid),   32'd1);
        check({tag, ".conf"},    32'(bus.out_conf),    32'(conf));
        check({tag, ".rs1"},     32'(bus.out_rs1),     32'(rs1));
        check({tag, ".rs2"},     32'(bus.out_rs2),     32'(rs2));
        check({tag, ".rd"},      32'(bus.out_rd),      32'(rd));
        check({tag, ".imm"},     bus.out_imm,          imm);
        check({tag, ".use_imm"}, 32'(bus.out_use_imm), 32'(use_imm));
        check({tag, ".illegal"}, 32'(bus.out_illegal), 32'(illegal));
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.out_ready = 1'b0;

        // ---------------- reset state ----------------
        #12;
        check("rst.out_valid", 32'(bus.out_valid),   32'd0);
        check("rst.in_ready",  32'(bus.in_ready),    32'd1);
        check("rst.conf",      32'(bus.out_conf),    32'(add_conf));
        check("rst.rs1",       32'(bus.out_rs1),     32'd0);
        check("rst.rd",        32'(bus.out_rd),      32'd0);
        check("rst.imm",       bus.out_imm,          32'd0);
        check("rst.use_imm",   32'(bus.out_use_imm), 32'd0);
        check("rst.illegal",   32'(bus.out_illegal), 32'd0);
`ifdef IEXU_ILLEGAL_CNT_EN
        check("rst.illegal_cnt", 32'(bus.illegal_cnt), 32'd0);
`endif
        rst_n = 1'b1;

        // ---------------- streaming decode, out_ready=1 ----------------
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instr  = I_ADD;  step();
        expect_entry("add",  add_conf, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b0);
        bus.in_instr  = I_SUB;  step();
        expect_entry("sub",  sub_conf, 5'd6, 5'd7, 5'd5, 32'd0, 1'b0, 1'b0);
        bus.in_instr  = I_ADDI; step();
        expect_entry("addi", add_conf, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b0);
        bus.in_instr  = I_SRAI; step();
        expect_entry("srai", sra_conf, 5'd2, 5'd0, 5'd2, 32'd4, 1'b1, 1'b0);
        bus.in_instr  = I_XOR;  step();
        expect_entry("xor",  xor_conf, 5'd5, 5'd6, 5'd4, 32'd0, 1'b0, 1'b0);
        bus.in_instr  = I_ANDI; step();
        expect_entry("andi", and_conf, 5'd8, 5'd0, 5'd7, 32'h000007FF, 1'b1, 1'b0);
        bus.in_instr  = I_SLLI; step();
        expect_entry("slli", sll_conf, 5'd9, 5'd0, 5'd9, 32'd31, 1'b1, 1'b0);

        // ---------------- illegal words ----------------
        bus.in_instr  = I_SLT;  step();
        expect_entry("slt",  add_conf, 5'd1, 5'd2, 5'd0, 32'd0, 1'b0, 1'b1);
`ifdef IEXU_ILLEGAL_CNT_EN
        check("cnt.before_xfer", 32'(bus.illegal_cnt), 32'd0);
`endif
        bus.in_instr  = I_LUI;  step();
        expect_entry("lui",  add_conf, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1);
`ifdef IEXU_ILLEGAL_CNT_EN
        check("cnt.after_slt", 32'(bus.illegal_cnt), 32'd1);
`endif
        bus.in_instr  = I_BADSR; step();
        expect_entry("badsr", add_conf, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1);
        bus.in_valid  = 1'b0;   step();
        check("drain.out_valid", 32'(bus.out_valid), 32'd0);
`ifdef IEXU_ILLEGAL_CNT_EN
        check("cnt.after_three", 32'(bus.illegal_cnt), 32'd3);
`endif

        // ---------------- backpressure: A,B,C with out_ready=0 ----------------
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = I_ADD;  step();     // A -> main
        check("bp.A.rd",       32'(bus.out_rd),   32'd3);
        check("bp.A.in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_instr  = I_SUB;  step();     // B -> skid
        check("bp.B.in_ready", 32'(bus.in_ready), 32'd0);
        check("bp.stall1.rd",  32'(bus.out_rd),   32'd3);
        bus.in_instr  = I_XOR;  step();     // C held at input
        check("bp.stall2.rd",  32'(bus.out_rd),   32'd3);
        check("bp.stall2.conf",32'(bus.out_conf), 32'(add_conf));
        check("bp.stall2.in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;   step();     // A leaves, B moves up
        check("bp.out1.rd",    32'(bus.out_rd),   32'd5);
        check("bp.out1.conf",  32'(bus.out_conf), 32'(sub_conf));
        check("bp.out1.in_ready", 32'(bus.in_ready), 32'd1);
        step();                             // B leaves, C accepted
        check("bp.out2.valid", 32'(bus.out_valid), 32'd1);
        check("bp.out2.rd",    32'(bus.out_rd),   32'd4);
        check("bp.out2.conf",  32'(bus.out_conf), 32'(xor_conf));
        bus.in_valid  = 1'b0;   step();     // C leaves, nothing behind it
        check("bp.empty.valid", 32'(bus.out_valid), 32'd0);

        // ---------------- flush with both entries full ----------------
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = I_ADD;  step();
        bus.in_instr  = I_SUB;  step();
        check("fl1.pre.in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_instr  = I_XOR;
        bus.flush     = 1'b1;   step();
        bus.flush     = 1'b0;
        check("fl1.out_valid", 32'(bus.out_valid), 32'd0);
        check("fl1.in_ready",  32'(bus.in_ready),  32'd1);

        // ---------------- flush discards an input accepted that cycle ----------
        bus.in_instr  = I_ADDI; step();     // main full, in_ready still 1
        check("fl2.pre.valid",    32'(bus.out_valid), 32'd1);
        check("fl2.pre.in_ready", 32'(bus.in_ready),  32'd1);
        bus.in_instr  = I_XOR;
        bus.flush     = 1'b1;   step();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        check("fl2.out_valid", 32'(bus.out_valid), 32'd0);
        check("fl2.in_ready",  32'(bus.in_ready),  32'd1);
        bus.out_ready = 1'b1;   step();
        check("fl2.discarded", 32'(bus.out_valid), 32'd0);
`ifdef IEXU_ILLEGAL_CNT_EN
        check("cnt.after_flush", 32'(bus.illegal_cnt), 32'd3);
`endif

        // ---------------- asynchronous reset mid-transfer ----------------
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = I_ADD;  step();
        bus.in_instr  = I_SUB;  step();
        bus.in_valid  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst.out_valid", 32'(bus.out_valid), 32'd0);
        check("arst.in_ready",  32'(bus.in_ready),  32'd1);
        check("arst.rd",        32'(bus.out_rd),    32'd0);
        #3 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        check("arst.skid_gone", 32'(bus.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
